// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle multiply/divide unit with its own HI/LO registers,
// used in the EX stage. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
// While a long operation runs it asks the pipeline controller to stall.
//
// Parameters
//   WIDTH    operand width (even, >= 4); HI and LO are each WIDTH bits
//   MUL_ITER 1 = shift-add multiply over WIDTH cycles, 0 = single-cycle multiply
// Ports
//   clk, rst        clock, synchronous active-high reset
//   op_valid, op    operation presented by EX (001 MULT, 010 MULTU, 011 DIV,
//                   100 DIVU, 101 MTHI, 110 MTLO; 000/111 no-op)
//   src_a, src_b    rs / rt operand values
//   annul           flush: abandon any operation, leave HI/LO untouched
//   ex_hold         EX frozen by another stall source (keeps DONE from retiring)
//   stallreq        combinational stall request to the pipeline controller
//   busy            registered, high whenever the unit is not idle
//   hi, lo          HI / LO registers
module muldiv_unit #(
  parameter int WIDTH    = 32,
  parameter bit MUL_ITER = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             annul,
  input  logic             ex_hold,
  output logic             stallreq,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ZERO, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;   // negate product / quotient
  logic               neg_rem_q, neg_rem_d;   // negate remainder (dividend sign)
  // Multiply: mcand = multiplicand, lower = multiplier, upper = partial sum.
  // Divide:   mcand = divisor, lower = dividend shifting out / quotient
  //           shifting in, upper = partial remainder.
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   upper_q, upper_d;
  logic [WIDTH-1:0]   lower_q, lower_d;

  // Operand decode and magnitudes, used only while sampling in IDLE.
  logic               op_mul, op_div, op_signed;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] prod_u, prod_c;

  assign op_mul    = (op == OP_MULT) || (op == OP_MULTU);
  assign op_div    = (op == OP_DIV)  || (op == OP_DIVU);
  assign op_signed = (op == OP_MULT) || (op == OP_DIV);
  assign a_neg     = op_signed & src_a[WIDTH-1];
  assign b_neg     = op_signed & src_b[WIDTH-1];
  assign a_mag     = a_neg ? -src_a : src_a;
  assign b_mag     = b_neg ? -src_b : src_b;
  assign prod_u    = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
  assign prod_c    = (a_neg ^ b_neg) ? -prod_u : prod_u;

  // One iteration of shift-add multiply or restoring divide.
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH-1:0]   rem_diff;
  logic               rem_ge;
  logic [WIDTH-1:0]   step_upper, step_lower;
  logic [2*WIDTH-1:0] fin_prod;
  logic [WIDTH-1:0]   fin_quo, fin_rem;

  always_comb begin
    mul_sum  = {1'b0, upper_q} + (lower_q[0] ? {1'b0, mcand_q} : '0);
    rem_sh   = {upper_q, lower_q[WIDTH-1]};
    rem_ge   = rem_sh >= {1'b0, mcand_q};
    // When rem_ge holds the true difference is below the divisor, so the
    // low WIDTH bits of the subtraction are exact.
    rem_diff = rem_sh[WIDTH-1:0] - mcand_q;
    if (is_div_q) begin
      step_upper = rem_ge ? rem_diff : rem_sh[WIDTH-1:0];
      step_lower = {lower_q[WIDTH-2:0], rem_ge};
    end else begin
      step_upper = mul_sum[WIDTH:1];
      step_lower = {mul_sum[0], lower_q[WIDTH-1:1]};
    end
    fin_prod = neg_res_q ? -{step_upper, step_lower} : {step_upper, step_lower};
    fin_quo  = neg_res_q ? -step_lower : step_lower;
    fin_rem  = neg_rem_q ? -step_upper : step_upper;
  end

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    mcand_d   = mcand_q;
    upper_d   = upper_q;
    lower_d   = lower_q;
    stallreq  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          if (op == OP_MTHI) hi_d = src_a;
          if (op == OP_MTLO) lo_d = src_a;
          if (op_mul || op_div) begin
            stallreq  = 1'b1;
            cnt_d     = '0;
            is_div_d  = op_div;
            neg_res_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            upper_d   = '0;
            mcand_d   = op_div ? b_mag : a_mag;
            lower_d   = op_div ? a_mag : b_mag;
            if (op_div && (src_b == '0)) begin
              state_d = S_ZERO;
            end else if (op_mul && !MUL_ITER) begin
              hi_d    = prod_c[2*WIDTH-1:WIDTH];
              lo_d    = prod_c[WIDTH-1:0];
              state_d = S_DONE;
            end else begin
              state_d = S_BUSY;
            end
          end
        end
      end
      S_BUSY: begin
        stallreq = 1'b1;
        upper_d  = step_upper;
        lower_d  = step_lower;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          if (is_div_q) begin
            hi_d = fin_rem;
            lo_d = fin_quo;
          end else begin
            hi_d = fin_prod[2*WIDTH-1:WIDTH];
            lo_d = fin_prod[WIDTH-1:0];
          end
          state_d = S_DONE;
        end
      end
      S_ZERO: begin
        // The divide is still held in EX here, so src_a is still the dividend.
        stallreq = 1'b1;
        hi_d     = src_a;
        lo_d     = '1;
        state_d  = S_DONE;
      end
      default: begin
        // DONE: results already written; a held EX must not re-execute.
        if (!ex_hold) state_d = S_IDLE;
      end
    endcase

    if (annul) begin
      stallreq = 1'b0;
      state_d  = S_IDLE;
      hi_d     = hi_q;
      lo_d     = lo_q;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      mcand_q   <= '0;
      upper_q   <= '0;
      lower_q   <= '0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      mcand_q   <= mcand_d;
      upper_q   <= upper_d;
      lower_q   <= lower_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit. Three instances cover the iterative 32-bit
// unit, the single-cycle-multiply 32-bit unit and an iterative 8-bit unit;
// "sel" chooses which one receives op_valid and whose outputs are observed.
// Expected results are queued when an op is issued and popped once the unit
// stops stalling.
module tb_muldiv_unit;

  localparam logic [2:0] MULT = 3'b001, MULTU = 3'b010, DIV = 3'b011,
                         DIVU = 3'b100, MTHI = 3'b101, MTLO = 3'b110;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_valid = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] src_a = '0, src_b = '0;
  logic        annul = 1'b0, ex_hold = 1'b0;
  int          sel = 0;

  logic        stall0, stall1, stall2, busy0, busy1, busy2;
  logic [31:0] hi0, lo0, hi1, lo1;
  logic [7:0]  hi2, lo2;
  logic        stall_m, busy_m;
  logic [31:0] hi_m, lo_m;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
    int          stall;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32), .MUL_ITER(1'b1)) u_it32 (
    .clk(clk), .rst(rst), .op_valid(op_valid && (sel == 0)), .op(op),
    .src_a(src_a), .src_b(src_b), .annul(annul), .ex_hold(ex_hold),
    .stallreq(stall0), .busy(busy0), .hi(hi0), .lo(lo0));

  muldiv_unit #(.WIDTH(32), .MUL_ITER(1'b0)) u_cm32 (
    .clk(clk), .rst(rst), .op_valid(op_valid && (sel == 1)), .op(op),
    .src_a(src_a), .src_b(src_b), .annul(annul), .ex_hold(ex_hold),
    .stallreq(stall1), .busy(busy1), .hi(hi1), .lo(lo1));

  muldiv_unit #(.WIDTH(8), .MUL_ITER(1'b1)) u_it8 (
    .clk(clk), .rst(rst), .op_valid(op_valid && (sel == 2)), .op(op),
    .src_a(src_a[7:0]), .src_b(src_b[7:0]), .annul(annul), .ex_hold(ex_hold),
    .stallreq(stall2), .busy(busy2), .hi(hi2), .lo(lo2));

  always_comb begin
    stall_m = stall0;
    busy_m  = busy0;
    hi_m    = hi0;
    lo_m    = lo0;
    if (sel == 1) begin
      stall_m = stall1; busy_m = busy1; hi_m = hi1; lo_m = lo1;
    end else if (sel == 2) begin
      stall_m = stall2; busy_m = busy2; hi_m = {24'h0, hi2}; lo_m = {24'h0, lo2};
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op at cycle 0 and count stalled cycles until the first
  // non-stalled cycle; returns with EX still presenting the op in that cycle.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int n);
    @(posedge clk); #1;
    op_valid = 1'b1; op = o; src_a = a; src_b = b;
    n = 0;
    @(negedge clk);
    while (stall_m === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int exp_stall);
    exp_t e;
    int   n;
    e = '{tag, exp_hi, exp_lo, exp_stall};
    sb.push_back(e);
    issue(o, a, b, n);
    e = sb.pop_front();
    check({e.tag, " stall"}, n, e.stall);
    if (e.stall > 0) check({e.tag, " busy_done"}, {31'h0, busy_m}, 32'h1);
    @(posedge clk); #1;
    op_valid = 1'b0; op = 3'b000;
    @(negedge clk);
    check({e.tag, " hi"}, hi_m, e.hi);
    check({e.tag, " lo"}, lo_m, e.lo);
    check({e.tag, " busy_idle"}, {31'h0, busy_m}, 32'h0);
    $display("txn %s sel=%0d stall=%0d hi=%h lo=%h", e.tag, sel, n, hi_m, lo_m);
  endtask

  initial begin
    int n;
    exp_t e;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset hi", hi_m, 32'h0);
    check("reset lo", lo_m, 32'h0);
    check("reset busy", {31'h0, busy_m}, 32'h0);
    check("reset stall", {31'h0, stall_m}, 32'h0);

    // Iterative 32-bit unit
    sel = 0;
    run_op("mult_neg2x3", MULT, 32'hFFFF_FFFE, 32'h3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 33);
    run_op("div_m7_2", DIV, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    run_op("divu_by0", DIVU, 32'h64, 32'h0, 32'h0000_0064, 32'hFFFF_FFFF, 2);
    run_op("div_minneg", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 33);
    run_op("mult_7xm5", MULT, 32'h7, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFDD, 33);
    run_op("divu_big", DIVU, 32'hFFFF_FFFF, 32'hA, 32'h5, 32'h1999_9999, 33);
    run_op("mthi", MTHI, 32'h1111, 32'h0, 32'h1111, 32'h1999_9999, 0);

    // Annul in cycle 10 of DIVU 100/7
    @(posedge clk); #1;
    op_valid = 1'b1; op = DIVU; src_a = 32'd100; src_b = 32'd7;
    repeat (10) @(posedge clk);
    #1 annul = 1'b1; op_valid = 1'b0;
    @(negedge clk);
    check("annul stall", {31'h0, stall_m}, 32'h0);
    @(posedge clk); #1 annul = 1'b0;
    @(negedge clk);
    check("annul busy", {31'h0, busy_m}, 32'h0);
    check("annul idle stall", {31'h0, stall_m}, 32'h0);
    check("annul hi", hi_m, 32'h1111);
    check("annul lo", lo_m, 32'h1999_9999);
    $display("txn annul_divu sel=%0d hi=%h lo=%h", sel, hi_m, lo_m);

    // DIVU 100/7 with EX held for three DONE cycles
    e = '{"hold_divu", 32'd2, 32'd14, 33};
    sb.push_back(e);
    issue(DIVU, 32'd100, 32'd7, n);
    e = sb.pop_front();
    ex_hold = 1'b1;
    check("hold stall", n, e.stall);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        @(negedge clk);
      end
      check("hold nostall", {31'h0, stall_m}, 32'h0);
      check("hold busy", {31'h0, busy_m}, 32'h1);
      check("hold hi", hi_m, e.hi);
      check("hold lo", lo_m, e.lo);
    end
    @(posedge clk); #1 ex_hold = 1'b0;
    @(negedge clk);
    check("release nostall", {31'h0, stall_m}, 32'h0);
    @(posedge clk); #1 op_valid = 1'b0;
    @(negedge clk);
    check("release busy", {31'h0, busy_m}, 32'h0);
    check("release lo", lo_m, e.lo);
    $display("txn %s sel=%0d stall=%0d hi=%h lo=%h", e.tag, sel, n, hi_m, lo_m);

    run_op("mtlo", MTLO, 32'hABCD, 32'h0, 32'd2, 32'hABCD, 0);

    // Reset in the middle of a multiply
    @(posedge clk); #1;
    op_valid = 1'b1; op = MULT; src_a = 32'd5; src_b = 32'd6;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; op_valid = 1'b0;
    @(negedge clk);
    check("rst busy", {31'h0, busy_m}, 32'h0);
    check("rst stall", {31'h0, stall_m}, 32'h0);
    check("rst hi", hi_m, 32'h0);
    check("rst lo", lo_m, 32'h0);
    $display("txn rst_mid_busy sel=%0d hi=%h lo=%h", sel, hi_m, lo_m);

    // Single-cycle multiply unit
    sel = 1;
    run_op("multu_ones", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1);
    run_op("mult_m3x4", MULT, 32'hFFFF_FFFD, 32'h4, 32'hFFFF_FFFF, 32'hFFFF_FFF4, 1);

    // Iterative 8-bit unit
    sel = 2;
    run_op("div8_81_3", DIV, 32'h81, 32'h03, 32'hFF, 32'hD6, 9);
    run_op("mult8_m16x5", MULT, 32'hF0, 32'h05, 32'hFF, 32'hB0, 9);
    run_op("divu8_by0", DIVU, 32'h08, 32'h00, 32'h08, 32'hFF, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
